output_arb_rr: RTL

OUTPUT_ARB_RR -- requirements
Module: output_arb_rr

---
 rtl/acc_pkg.sv | 12 +
 rtl/rr_penc.sv | 26 ++
 rtl/output_arb_rr.sv | 118 +++++++++++
 3 files changed

// File: rtl/acc_pkg.sv
// Shared types and constants for the round-robin AXI write output arbiter.
package acc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  localparam logic [1:0] AXI_OKAY = 2'b00;

endpackage

// File: rtl/rr_penc.sv
// Combinational round-robin priority encoder: first requester after 'last', wrapping.
module rr_penc #(
  parameter int NP = 4,
  parameter int IW = (NP > 1) ? $clog2(NP) : 1
) (
  input  logic [NP-1:0] req,
  input  logic [IW-1:0] last,
  output logic [IW-1:0] gnt,
  output logic          any
);

  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment, so no path leaves it unassigned (no latch).
  always_comb begin
    gnt = '0;
    any = 1'b0;
    // Walk from the farthest offset down so the nearest requester wins last.
    for (int off = NP; off >= 1; off--) begin
      if (req[(int'(last) + off) % NP]) begin
        gnt = IW'((int'(last) + off) % NP);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/output_arb_rr.sv
// Round-robin arbiter funnelling NP write-burst channels onto one AXI write port.
module output_arb_rr
  import acc_pkg::*;
#(
  parameter int NP     = 4,
  parameter int DW     = 64,
  parameter int AW     = 40,
  parameter int MAXOUT = 4
) (
  input  logic              aclk,
  input  logic              arst,
  input  logic [NP-1:0]     wreq,
  output logic [NP-1:0]     wack,
  input  logic [31:0]       wadr  [NP],
  input  logic [DW-1:0]     wdata [NP],
  input  logic [DW/8-1:0]   wstbi [NP],
  input  logic [7:0]        wlen  [NP],
  input  logic [31:0]       baseadr,
  output logic [AW-1:0]     awaddr,
  output logic [7:0]        awlen,
  output logic              awvalid,
  input  logic              awready,
  output logic [DW-1:0]     wr_data,
  output logic [DW/8-1:0]   wstb,
  output logic              wvalid,
  output logic              wlast,
  input  logic              wready,
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready,
  output logic              busy,
  output logic              err
);

  localparam int          CHW     = (NP > 1) ? $clog2(NP) : 1;
  localparam logic [3:0]  OUT_MAX = 4'(MAXOUT);

  state_t         state, state_nx;
  logic [CHW-1:0] ch, last, gnt;
  logic           any, grant;
  logic [7:0]     beat;
  logic [3:0]     outst;
  logic           aw_hs, w_hs, b_hs;
  logic [31:0]    adr_sum;
  logic           unused_adr_lsb;

  rr_penc #(.NP(NP), .IW(CHW)) u_penc (
    .req  (wreq),
    .last (last),
    .gnt  (gnt),
    .any  (any)
  );

  // Outputs are qualified with !arst so they sit at reset values for the whole pulse.
  assign awvalid = !arst && (state == ST_ADDR);
  assign wvalid  = !arst && (state == ST_DATA);
  assign bready  = !arst;
  assign busy    = !arst && ((state != ST_IDLE) || (outst != 4'd0));

  assign adr_sum        = baseadr + {wadr[ch][31:8], 8'h00};
  assign unused_adr_lsb = ^wadr[ch][7:0];
  assign awaddr         = AW'(adr_sum);
  assign awlen          = wlen[ch];
  assign wr_data        = wdata[ch];
  assign wstb           = wstbi[ch];
  assign wlast          = wvalid && (beat == awlen);

  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;
  assign b_hs  = bvalid && bready;

  always_comb begin
    wack = '0;
    if (w_hs) wack[ch] = 1'b1;
  end

  always_comb begin
    state_nx = state;
    grant    = 1'b0;
    unique case (state)
      ST_IDLE: if (any && (outst < OUT_MAX)) begin
        grant    = 1'b1;
        state_nx = ST_ADDR;
      end
      ST_ADDR: if (aw_hs) state_nx = ST_DATA;
      ST_DATA: if (w_hs && wlast) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; the reset here is synchronous, checked on the edge.
  always_ff @(posedge aclk) begin
    if (arst) begin
      state <= ST_IDLE;
      ch    <= '0;
      last  <= CHW'(NP - 1);
      beat  <= '0;
      outst <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nx;
      if (grant) begin
        ch   <= gnt;
        last <= gnt;
      end
      if (w_hs) beat <= wlast ? 8'd0 : beat + 8'd1;
      // A B response with nothing outstanding is ignored to keep the count sane.
      unique case ({aw_hs, b_hs && (outst != 4'd0)})
        2'b10:   outst <= outst + 4'd1;
        2'b01:   outst <= outst - 4'd1;
        default: outst <= outst;
      endcase
      if (b_hs && (bresp != AXI_OKAY)) err <= 1'b1;
    end
  end

endmodule
